// File: rtl/axi_rt_pkg.sv
// Shared types for the RT configuration sequencer: FSM state encoding and
// the packed active-configuration record loaded atomically on commit.
package axi_rt_pkg;

  // Default geometry of the RT unit. The active-configuration struct is
  // built from these widths, so the top-level parameters must keep them.
  localparam int unsigned RtNumAddrRegions = 32'd2;
  localparam int unsigned RtPeriodWidth    = 32'd32;
  localparam int unsigned RtBudgetWidth    = 32'd32;

  typedef logic [RtNumAddrRegions-1:0][RtBudgetWidth-1:0] rt_budget_t;
  typedef logic [RtNumAddrRegions-1:0][RtPeriodWidth-1:0] rt_period_t;

  typedef struct packed {
    logic       rt_enable;
    logic       imtu_enable;
    logic [7:0] len_limit;
    rt_budget_t w_budget;
    rt_period_t w_period;
    rt_budget_t r_budget;
    rt_period_t r_period;
  } rt_cfg_t;

  typedef enum logic [2:0] {
    RtCfgIdle,
    RtCfgDrain,
    RtCfgApply,
    RtCfgSettle,
    RtCfgRelease
  } rt_cfg_state_e;

  // Power-on active configuration: everything off, budgets/periods zero.
  function automatic rt_cfg_t rt_cfg_rst(input logic [7:0] len_rst);
    rt_cfg_t c;
    c           = '0;
    c.len_limit = len_rst;
    return c;
  endfunction

endpackage

// File: rtl/axi_rt_cfg_timeout_cnt.sv
// Drain watchdog counter: synchronous clear, count enable, saturation at
// all-ones, and an equality flag against a compare value.
module axi_rt_cfg_timeout_cnt #(
  parameter int unsigned Width = 32'd16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] cmp_i,
  output logic             eq_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == cmp_i);

endmodule

// File: rtl/axi_rt_cfg_sequencer.sv
// Commits a staged RT configuration into the RT unit: isolate upstream,
// wait for drain, load all fields in one cycle, restart budget periods,
// wait for bypass to settle, then release traffic.
module axi_rt_cfg_sequencer
  import axi_rt_pkg::*;
#(
  parameter int unsigned NumAddrRegions = RtNumAddrRegions,
  parameter int unsigned PeriodWidth    = RtPeriodWidth,
  parameter int unsigned BudgetWidth    = RtBudgetWidth,
  parameter int unsigned IdxWWidth      = 32'd4,
  parameter int unsigned IdxAwWidth     = 32'd4,
  parameter int unsigned TimeoutWidth   = 32'd16,
  parameter logic [7:0]  LenLimitRst    = 8'hFF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  cfg_rt_enable_i,
  input  logic                                  cfg_imtu_enable_i,
  input  logic [7:0]                            cfg_len_limit_i,
  input  logic [NumAddrRegions*BudgetWidth-1:0] cfg_w_budget_i,
  input  logic [NumAddrRegions*PeriodWidth-1:0] cfg_w_period_i,
  input  logic [NumAddrRegions*BudgetWidth-1:0] cfg_r_budget_i,
  input  logic [NumAddrRegions*PeriodWidth-1:0] cfg_r_period_i,
  input  logic [TimeoutWidth-1:0]               timeout_i,
  input  logic                                  commit_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  timeout_o,
  output logic                                  hold_o,
  input  logic                                  isolated_i,
  input  logic [IdxWWidth-1:0]                  num_w_pending_i,
  input  logic [IdxAwWidth-1:0]                 num_aw_pending_i,
  input  logic                                  rt_bypassed_i,
  output logic                                  rt_enable_o,
  output logic                                  imtu_enable_o,
  output logic                                  imtu_abort_o,
  output logic [7:0]                            len_limit_o,
  output logic [NumAddrRegions*BudgetWidth-1:0] w_budget_o,
  output logic [NumAddrRegions*PeriodWidth-1:0] w_period_o,
  output logic [NumAddrRegions*BudgetWidth-1:0] r_budget_o,
  output logic [NumAddrRegions*PeriodWidth-1:0] r_period_o
);

  rt_cfg_state_e state_q, state_d;
  rt_cfg_t       cfg_q, cfg_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          abort_q, abort_d;

  logic                    cnt_clr, cnt_en, cnt_eq;
  logic [TimeoutWidth-1:0] cnt_cmp;
  logic                    drain_ok;
  logic                    timeout_hit;

  assign drain_ok    = isolated_i && (num_w_pending_i == '0) && (num_aw_pending_i == '0);
  assign cnt_cmp     = timeout_i - TimeoutWidth'(1);
  assign timeout_hit = (timeout_i != '0) && cnt_eq;

  axi_rt_cfg_timeout_cnt #(
    .Width (TimeoutWidth)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cmp_i  (cnt_cmp),
    .eq_o   (cnt_eq)
  );

  // Commit sequencing: next state and next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    abort_d   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      RtCfgIdle: begin
        if (commit_i) begin
          state_d   = RtCfgDrain;
          hold_d    = 1'b1;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      RtCfgDrain: begin
        cnt_en = 1'b1;
        // A drain completing on the timeout boundary still counts as success.
        if (drain_ok) begin
          state_d = RtCfgApply;
        end else if (timeout_hit) begin
          state_d   = RtCfgRelease;
          hold_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      RtCfgApply: begin
        cfg_d.rt_enable   = cfg_rt_enable_i;
        cfg_d.imtu_enable = cfg_imtu_enable_i;
        cfg_d.len_limit   = cfg_len_limit_i;
        cfg_d.w_budget    = cfg_w_budget_i;
        cfg_d.w_period    = cfg_w_period_i;
        cfg_d.r_budget    = cfg_r_budget_i;
        cfg_d.r_period    = cfg_r_period_i;
        abort_d           = 1'b1;
        state_d           = RtCfgSettle;
      end
      RtCfgSettle: begin
        if (rt_bypassed_i == !cfg_q.rt_enable) begin
          state_d = RtCfgRelease;
          hold_d  = 1'b0;
        end
      end
      RtCfgRelease: begin
        if (!isolated_i) begin
          state_d = RtCfgIdle;
          done_d  = !timeout_q;
        end
      end
      default: begin
        state_d = RtCfgIdle;
        hold_d  = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RtCfgIdle;
      cfg_q     <= rt_cfg_rst(LenLimitRst);
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      abort_q   <= abort_d;
    end
  end

  assign busy_o        = (state_q != RtCfgIdle);
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign hold_o        = hold_q;
  assign imtu_abort_o  = abort_q;
  assign rt_enable_o   = cfg_q.rt_enable;
  assign imtu_enable_o = cfg_q.imtu_enable;
  assign len_limit_o   = cfg_q.len_limit;
  assign w_budget_o    = cfg_q.w_budget;
  assign w_period_o    = cfg_q.w_period;
  assign r_budget_o    = cfg_q.r_budget;
  assign r_period_o    = cfg_q.r_period;

endmodule

// File: tb/tb_axi_rt_cfg_sequencer.sv
// Bench for axi_rt_cfg_sequencer: directed scenarios plus randomized commits
// checked against a transaction-level model of commit outcome and timing.
module tb_axi_rt_cfg_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_rt_enable_i = 1'b0;
  logic        cfg_imtu_enable_i = 1'b0;
  logic [7:0]  cfg_len_limit_i = '0;
  logic [63:0] cfg_w_budget_i = '0;
  logic [63:0] cfg_w_period_i = '0;
  logic [63:0] cfg_r_budget_i = '0;
  logic [63:0] cfg_r_period_i = '0;
  logic [15:0] timeout_i = '0;
  logic        commit_i = 1'b0;
  logic        busy_o, done_o, timeout_o, hold_o;
  logic        isolated_i;
  logic [3:0]  num_w_pending_i = '0;
  logic [3:0]  num_aw_pending_i = '0;
  logic        rt_bypassed_i = 1'b1;
  logic        rt_enable_o, imtu_enable_o, imtu_abort_o;
  logic [7:0]  len_limit_o;
  logic [63:0] w_budget_o, w_period_o, r_budget_o, r_period_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Environment knobs for the emulated RT unit / upstream path.
  int unsigned aw_cycles = 0;
  bit          iso_block = 1'b0;
  int unsigned byp_dly   = 1;

  // Model of the active configuration.
  bit          exp_en   = 1'b0;
  bit          exp_imtu = 1'b0;
  logic [7:0]  exp_len  = 8'hFF;
  logic [63:0] exp_wb = '0, exp_wp = '0, exp_rb = '0, exp_rp = '0;

  always #5 clk_i = ~clk_i;

  assign isolated_i = hold_o & ~iso_block;

  axi_rt_cfg_sequencer #(
    .NumAddrRegions (32'd2),
    .PeriodWidth    (32'd32),
    .BudgetWidth    (32'd32),
    .IdxWWidth      (32'd4),
    .IdxAwWidth     (32'd4),
    .TimeoutWidth   (32'd16),
    .LenLimitRst    (8'hFF)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .cfg_rt_enable_i   (cfg_rt_enable_i),
    .cfg_imtu_enable_i (cfg_imtu_enable_i),
    .cfg_len_limit_i   (cfg_len_limit_i),
    .cfg_w_budget_i    (cfg_w_budget_i),
    .cfg_w_period_i    (cfg_w_period_i),
    .cfg_r_budget_i    (cfg_r_budget_i),
    .cfg_r_period_i    (cfg_r_period_i),
    .timeout_i         (timeout_i),
    .commit_i          (commit_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .timeout_o         (timeout_o),
    .hold_o            (hold_o),
    .isolated_i        (isolated_i),
    .num_w_pending_i   (num_w_pending_i),
    .num_aw_pending_i  (num_aw_pending_i),
    .rt_bypassed_i     (rt_bypassed_i),
    .rt_enable_o       (rt_enable_o),
    .imtu_enable_o     (imtu_enable_o),
    .imtu_abort_o      (imtu_abort_o),
    .len_limit_o       (len_limit_o),
    .w_budget_o        (w_budget_o),
    .w_period_o        (w_period_o),
    .r_budget_o        (r_budget_o),
    .r_period_o        (r_period_o)
  );

  // Emulated RT unit: pending traffic for the first aw_cycles held cycles,
  // bypass status following !rt_enable_o after byp_dly cycles.
  initial begin
    int unsigned dcnt;
    int unsigned byp_cnt;
    dcnt    = 0;
    byp_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (hold_o && (dcnt < aw_cycles)) begin
        num_aw_pending_i = 4'd2;
        num_w_pending_i  = 4'd1;
      end else begin
        num_aw_pending_i = '0;
        num_w_pending_i  = '0;
      end
      dcnt = hold_o ? dcnt + 1 : 0;
      if (rt_bypassed_i == rt_enable_o) begin
        byp_cnt++;
        if (byp_cnt >= byp_dly) begin
          rt_bypassed_i = ~rt_bypassed_i;
          byp_cnt       = 0;
        end
      end else begin
        byp_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_cfg(input string nm);
    chk({nm, ".rt_en"},  rt_enable_o,   exp_en);
    chk({nm, ".imtu"},   imtu_enable_o, exp_imtu);
    chk({nm, ".len"},    len_limit_o,   exp_len);
    chk({nm, ".wb"},     w_budget_o,    exp_wb);
    chk({nm, ".wp"},     w_period_o,    exp_wp);
    chk({nm, ".rb"},     r_budget_o,    exp_rb);
    chk({nm, ".rp"},     r_period_o,    exp_rp);
  endtask

  task automatic rand_cfg();
    cfg_rt_enable_i   = 1'($urandom_range(0, 1));
    cfg_imtu_enable_i = 1'($urandom_range(0, 1));
    cfg_len_limit_i   = 8'($urandom);
    cfg_w_budget_i    = {$urandom, $urandom};
    cfg_w_period_i    = {$urandom, $urandom};
    cfg_r_budget_i    = {$urandom, $urandom};
    cfg_r_period_i    = {$urandom, $urandom};
  endtask

  // One commit: d = cycles of pending traffic, t = timeout, blk = isolation
  // never acknowledged, bd = bypass response delay, dup = second commit pulse.
  task automatic do_commit(input string nm, input int unsigned d, input int unsigned t,
                           input bit blk, input int unsigned bd, input bit dup);
    bit          ok;
    int unsigned s, cyc, dn, ab, hc, done_cyc, ab_cyc, idle_cyc, bad_cfg, extra;
    ok        = (t == 0) || (!blk && (d <= t - 1));
    s         = (cfg_rt_enable_i != exp_en) ? bd : 1;
    aw_cycles = d;
    iso_block = blk;
    byp_dly   = bd;
    timeout_i = t[15:0];
    cyc = 0; dn = 0; ab = 0; hc = 0; done_cyc = 0; ab_cyc = 0; idle_cyc = 0;
    bad_cfg = 0; extra = 0;
    @(negedge clk_i);
    commit_i = 1'b1;
    while ((idle_cyc == 0) && (cyc < 300)) begin
      @(negedge clk_i);
      cyc++;
      commit_i = dup && (cyc == 2);
      if (hold_o) hc++;
      if (done_o) begin dn++; done_cyc = cyc; end
      if (imtu_abort_o) begin ab++; ab_cyc = cyc; end
      if (ab == 0) begin
        if ((len_limit_o != exp_len) || (rt_enable_o != exp_en) ||
            (w_budget_o != exp_wb) || (r_period_o != exp_rp)) bad_cfg++;
      end else begin
        if ((len_limit_o != cfg_len_limit_i) || (rt_enable_o != cfg_rt_enable_i) ||
            (w_budget_o != cfg_w_budget_i) || (r_period_o != cfg_r_period_i)) bad_cfg++;
      end
      if (!busy_o) idle_cyc = cyc;
    end
    commit_i = 1'b0;
    chk({nm, ".finished"}, (idle_cyc != 0), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o || imtu_abort_o) extra++;
    end
    chk({nm, ".busy_end"}, idle_cyc, ok ? (d + s + 4) : (t + 2));
    chk({nm, ".done_cnt"}, dn, ok);
    chk({nm, ".abort_cnt"}, ab, ok);
    chk({nm, ".hold_cyc"}, hc, ok ? (d + s + 2) : t);
    chk({nm, ".timeout"}, timeout_o, !ok);
    chk({nm, ".cfg_seq"}, bad_cfg, 0);
    chk({nm, ".quiet"}, extra, 0);
    if (ok) begin
      chk({nm, ".done_cyc"}, done_cyc, d + s + 4);
      chk({nm, ".abort_cyc"}, ab_cyc, d + 3);
      exp_en   = cfg_rt_enable_i;
      exp_imtu = cfg_imtu_enable_i;
      exp_len  = cfg_len_limit_i;
      exp_wb   = cfg_w_budget_i;
      exp_wp   = cfg_w_period_i;
      exp_rb   = cfg_r_budget_i;
      exp_rp   = cfg_r_period_i;
    end
    chk_cfg(nm);
  endtask

  initial begin
    int unsigned d, t, mode, bd, guard;
    bit          blk, dup;

    repeat (3) @(negedge clk_i);
    chk("rst.busy", busy_o, 1'b0);
    chk("rst.done", done_o, 1'b0);
    chk("rst.timeout", timeout_o, 1'b0);
    chk("rst.hold", hold_o, 1'b0);
    chk("rst.abort", imtu_abort_o, 1'b0);
    chk_cfg("rst");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    rand_cfg();
    cfg_rt_enable_i   = 1'b1;
    cfg_imtu_enable_i = 1'b1;
    cfg_len_limit_i   = 8'h07;
    do_commit("basic", 0, 0, 1'b0, 2, 1'b0);

    rand_cfg();
    do_commit("drain", 10, 0, 1'b0, 1, 1'b0);

    rand_cfg();
    do_commit("tmo", 0, 16, 1'b1, 1, 1'b0);

    rand_cfg();
    do_commit("tie", 5, 6, 1'b0, 1, 1'b0);

    rand_cfg();
    do_commit("busy", 4, 0, 1'b0, 1, 1'b1);

    // Reset while waiting in SETTLE for a slow bypass response.
    rand_cfg();
    cfg_rt_enable_i = !exp_en;
    aw_cycles = 0;
    iso_block = 1'b0;
    byp_dly   = 20;
    timeout_i = '0;
    @(negedge clk_i);
    commit_i = 1'b1;
    @(negedge clk_i);
    commit_i = 1'b0;
    guard = 0;
    while (!imtu_abort_o && (guard < 50)) begin
      @(negedge clk_i);
      guard++;
    end
    chk("rstmid.reach_settle", imtu_abort_o, 1'b1);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    exp_en = 1'b0; exp_imtu = 1'b0; exp_len = 8'hFF;
    exp_wb = '0; exp_wp = '0; exp_rb = '0; exp_rp = '0;
    chk("rstmid.busy", busy_o, 1'b0);
    chk("rstmid.hold", hold_o, 1'b0);
    chk("rstmid.abort", imtu_abort_o, 1'b0);
    chk("rstmid.done", done_o, 1'b0);
    chk("rstmid.timeout", timeout_o, 1'b0);
    chk_cfg("rstmid");
    byp_dly = 1;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    rand_cfg();
    do_commit("after_rst", 1, 0, 1'b0, 2, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rand_cfg();
      d    = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      t    = (mode == 0) ? 0 : $urandom_range(1, 16);
      blk  = (mode == 3);
      bd   = $urandom_range(1, 4);
      dup  = 1'($urandom_range(0, 1));
      do_commit($sformatf("rnd%0d", i), d, t, blk, bd, dup);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rt_cfg_sequencer.md
Name: axi_rt_cfg_sequencer

Overview:
- Safely commits a staged real-time configuration into an `axi_rt_unit`. Covered fields: RT enable, IMTU enable, fragmentation length limit, and per-region read/write budgets and periods.
- Sits between the register file and the RT unit.
- On commit it holds upstream traffic, waits for the unit to drain and isolate, applies the new configuration atomically, restarts the budget periods, waits for the bypass state to settle, then releases traffic.
- A drain timeout aborts a commit that cannot complete.

Parameters:
- NumAddrRegions, 32'd2, number of budgeted address regions.
- PeriodWidth, 32'd32, width of a period value.
- BudgetWidth, 32'd32, width of a budget value.
- IdxWWidth, 32'd4, width of the W-pending count input.
- IdxAwWidth, 32'd4, width of the AW-pending count input.
- TimeoutWidth, 32'd16, width of the drain timeout counter.
- LenLimitRst, 8'hFF, reset value of len_limit_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_rt_enable_i  in  1  staged RT enable.
- cfg_imtu_enable_i  in  1  staged IMTU enable.
- cfg_len_limit_i  in  8  staged fragmentation limit.
- cfg_w_budget_i  in  NumAddrRegions*BudgetWidth  staged write budgets.
- cfg_w_period_i  in  NumAddrRegions*PeriodWidth  staged write periods.
- cfg_r_budget_i  in  NumAddrRegions*BudgetWidth  staged read budgets.
- cfg_r_period_i  in  NumAddrRegions*PeriodWidth  staged read periods.
- timeout_i  in  TimeoutWidth  maximum drain cycles; 0 = no timeout.
- commit_i  in  1  single-cycle commit request.
- busy_o  out  1  commit in progress.
- done_o  out  1  one-cycle pulse on successful commit.
- timeout_o  out  1  sticky drain-timeout error, cleared by the next accepted commit.
- hold_o  out  1  isolation request to the upstream path.
- isolated_i  in  1  upstream isolation acknowledge.
- num_w_pending_i  in  IdxWWidth  W beats buffered in the RT unit.
- num_aw_pending_i  in  IdxAwWidth  AWs buffered in the RT unit.
- rt_bypassed_i  in  1  RT unit bypass status.
- rt_enable_o  out  1  active RT enable.
- imtu_enable_o  out  1  active IMTU enable.
- imtu_abort_o  out  1  period restart pulse.
- len_limit_o  out  8  active fragmentation limit.
- w_budget_o, w_period_o, r_budget_o, r_period_o  out  as cfg_*  active values.

Behaviour:
- Reset values:
  - rt_enable_o=0, imtu_enable_o=0, len_limit_o=LenLimitRst, all budgets/periods=0.
  - busy_o=0, done_o=0, timeout_o=0, hold_o=0, imtu_abort_o=0.
  - State IDLE, timeout counter 0.
- All outputs are registered, except busy_o, which is (state != IDLE).
- FSM states: IDLE, DRAIN, APPLY, SETTLE, RELEASE.
- IDLE:
  - commit_i=1 -> DRAIN. Set hold_o=1, clear timeout_o, clear the counter.
  - commit_i is ignored outside IDLE; no queuing.
- DRAIN:
  - The counter increments each cycle and saturates at its maximum.
  - Exit to APPLY when isolated_i=1, num_w_pending_i=0 and num_aw_pending_i=0 are all true in the same cycle.
  - Otherwise, if timeout_i!=0 and the counter equals timeout_i-1 -> RELEASE with timeout_o=1 set. Active config is left unchanged.
  - If the drain condition and the timeout boundary coincide, the drain condition wins.
- APPLY (exactly 1 cycle):
  - Registers all cfg_* inputs into the active outputs, visible from the next cycle.
  - Asserts imtu_abort_o for exactly one cycle, coincident with the new values.
  - -> SETTLE.
  - The sampling instant is the APPLY cycle: cfg_* changes during DRAIN are picked up.
- SETTLE:
  - Wait until rt_bypassed_i == !rt_enable_o, then -> RELEASE.
  - If the enable did not change, this takes 1 cycle.
- RELEASE:
  - Deassert hold_o, wait for isolated_i=0, then -> IDLE.
  - done_o pulses on the IDLE-entry cycle only if no timeout occurred.
  - A timeout path ends with done_o=0 and timeout_o=1.
- hold_o is 1 from the cycle after the commit is accepted until RELEASE is entered.
- Minimum commit latency, commit_i to done_o, with all acks already present: 5 cycles.
- Reset mid-commit: all state and outputs return to their reset values immediately (asynchronous); the active configuration is lost.
- Counter width: TimeoutWidth; the comparison is unsigned.

Decomposition:
- Package axi_rt_pkg holds:
  - The state enum (`rt_cfg_state_e`).
  - A packed struct `rt_cfg_t` holding rt_enable, imtu_enable, len_limit and the budget/period arrays, parameterised through typedefs built from widths in the package defaults.
- The active configuration is a single `rt_cfg_t` register loaded in APPLY.
- One sub-module is natural: `axi_rt_cfg_timeout_cnt`, a clear/enable/saturating counter with a compare-equal output.

Test Plan:
- Basic commit:
  - Stimulus: acks immediate, cfg_len_limit=8'h07, cfg_rt_enable=1, rt_bypassed_i drops 2 cycles after APPLY.
  - Required: hold_o high, imtu_abort_o single pulse, len_limit_o=7 after APPLY, done_o pulse, hold_o low, busy_o low.
- Drain wait:
  - Stimulus: num_aw_pending_i=2 for 10 cycles, then 0.
  - Required: outputs unchanged during the wait, APPLY only after the count reaches 0, done_o asserted.
- Timeout:
  - Stimulus: timeout_i=16, isolated_i held 0.
  - Required: RELEASE after 16 DRAIN cycles, timeout_o=1, active budgets unchanged, no done_o, no imtu_abort_o.
- Timeout tie:
  - Stimulus: drain condition met exactly on the timeout cycle.
  - Required: commit succeeds, timeout_o=0.
- Commit while busy:
  - Stimulus: second commit_i pulse during DRAIN.
  - Required: ignored, exactly one done_o.
- Reset mid-commit:
  - Stimulus: rst_ni asserted in SETTLE.
  - Required: all outputs return to reset values asynchronously; after release, a fresh commit completes normally.
